// File: rtl/trapezoid_pkg.sv
// Shared types and constants for the trapezoid scanline rasterizer.
package trapezoid_pkg;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned ARITH_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad1,
        StLoad2,
        StLoad3,
        StSetup,
        StRow,
        StEmit,
        StStep
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } vertex_t;

    // Zero-extend a coordinate into the signed arithmetic width.
    function automatic logic signed [ARITH_W-1:0] widen(input logic [COORD_W-1:0] v);
        return {{(ARITH_W - COORD_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/trapezoid_edge_dda.sv
// Exact rational edge tracker: position is q + r/dy with 0 <= r < dy, stepped by dx/dy per row.
module trapezoid_edge_dda
    import trapezoid_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      step,
    input  logic signed [ARITH_W-1:0] x0,
    input  logic signed [ARITH_W-1:0] dx,
    input  logic signed [ARITH_W-1:0] dy,
    input  logic                      ceil_mode,
    output logic signed [ARITH_W-1:0] x_bound,
    output logic                      done
);

    localparam logic signed [ARITH_W-1:0] One = 1;

    logic signed [ARITH_W-1:0] q_q;
    logic signed [ARITH_W-1:0] r_q;
    logic signed [ARITH_W-1:0] dx_q;
    logic signed [ARITH_W-1:0] dy_q;
    logic                      r_neg;
    logic                      r_over;

    assign r_neg  = r_q[ARITH_W-1];
    assign r_over = !r_neg && (dy_q != '0) && (r_q >= dy_q);

    // Normalisation runs one dy per cycle whenever the remainder is out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= '0;
            r_q  <= '0;
            dx_q <= '0;
            dy_q <= '0;
        end else if (load) begin
            q_q  <= x0;
            r_q  <= '0;
            dx_q <= dx;
            dy_q <= dy;
        end else if (step) begin
            r_q <= r_q + dx_q;
        end else if (r_over) begin
            r_q <= r_q - dy_q;
            q_q <= q_q + One;
        end else if (r_neg) begin
            r_q <= r_q + dy_q;
            q_q <= q_q - One;
        end
    end

    always_comb begin
        done    = !r_neg && !r_over;
        x_bound = (ceil_mode && (r_q != '0)) ? q_q + One : q_q;
    end

endmodule

// File: rtl/trapezoid_render.sv
// Trapezoid scanline rasterizer: captures four vertices and streams one inside pixel per cycle.
module trapezoid_render
    import trapezoid_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               nt,
    input  logic [COORD_W-1:0] xi,
    input  logic [COORD_W-1:0] yi,
    output logic               busy,
    output logic               po,
    output logic [COORD_W-1:0] xo,
    output logic [COORD_W-1:0] yo
);

    state_e               state_q, state_d;
    vertex_t [3:0]        vtx_q, vtx_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic                 busy_q, busy_d;
    logic                 po_q, po_d;
    logic [COORD_W-1:0]   xo_q, xo_d;
    logic [COORD_W-1:0]   yo_q, yo_d;
    logic                 dda_load;
    logic                 dda_step;
    logic                 last_row;

    logic signed [ARITH_W-1:0] dy;
    logic signed [ARITH_W-1:0] dx_l;
    logic signed [ARITH_W-1:0] dx_r;
    logic signed [ARITH_W-1:0] l_bound;
    logic signed [ARITH_W-1:0] r_bound;
    logic                      l_done;
    logic                      r_done;

    // vtx[0]=(xul,yu) vtx[1]=(xur,yu) vtx[2]=(xdl,yd) vtx[3]=(xdr,yd)
    assign dy       = widen(vtx_q[0].y) - widen(vtx_q[2].y);
    assign dx_l     = widen(vtx_q[0].x) - widen(vtx_q[2].x);
    assign dx_r     = widen(vtx_q[1].x) - widen(vtx_q[3].x);
    assign last_row = (y_q == vtx_q[0].y);

    trapezoid_edge_dda u_left (
        .clk       (clk),
        .reset     (reset),
        .load      (dda_load),
        .step      (dda_step),
        .x0        (widen(vtx_q[2].x)),
        .dx        (dx_l),
        .dy        (dy),
        .ceil_mode (1'b1),
        .x_bound   (l_bound),
        .done      (l_done)
    );

    trapezoid_edge_dda u_right (
        .clk       (clk),
        .reset     (reset),
        .load      (dda_load),
        .step      (dda_step),
        .x0        (widen(vtx_q[3].x)),
        .dx        (dx_r),
        .dy        (dy),
        .ceil_mode (1'b0),
        .x_bound   (r_bound),
        .done      (r_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            vtx_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            po_q    <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
        end else begin
            state_q <= state_d;
            vtx_q   <= vtx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            po_q    <= po_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vtx_d    = vtx_q;
        y_d      = y_q;
        busy_d   = busy_q;
        po_d     = po_q;
        xo_d     = xo_q;
        yo_d     = yo_q;
        dda_load = 1'b0;
        dda_step = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (nt) begin
                    vtx_d[0] = vertex_t'{x: xi, y: yi};
                    state_d  = StLoad1;
                end
            end
            StLoad1: begin
                vtx_d[1] = vertex_t'{x: xi, y: yi};
                state_d  = StLoad2;
            end
            StLoad2: begin
                vtx_d[2] = vertex_t'{x: xi, y: yi};
                state_d  = StLoad3;
            end
            StLoad3: begin
                vtx_d[3] = vertex_t'{x: xi, y: yi};
                busy_d   = 1'b1;
                state_d  = StSetup;
            end
            StSetup: begin
                dda_load = 1'b1;
                y_d      = vtx_q[2].y;
                state_d  = StRow;
            end
            StRow: begin
                if (l_bound <= r_bound) begin
                    po_d    = 1'b1;
                    xo_d    = l_bound[COORD_W-1:0];
                    yo_d    = y_q;
                    state_d = StEmit;
                end else if (last_row) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    dda_step = 1'b1;
                    y_d      = y_q + 1'b1;
                    state_d  = StStep;
                end
            end
            StEmit: begin
                if (xo_q != r_bound[COORD_W-1:0]) begin
                    xo_d = xo_q + 1'b1;
                end else begin
                    po_d = 1'b0;
                    if (last_row) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        dda_step = 1'b1;
                        y_d      = y_q + 1'b1;
                        state_d  = StStep;
                    end
                end
            end
            StStep: begin
                if (l_done && r_done) begin
                    state_d = StRow;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = busy_q;
    assign po   = po_q;
    assign xo   = xo_q;
    assign yo   = yo_q;

endmodule

// File: tb/tb_trapezoid_render.sv
// Self-checking bench for trapezoid_render against an exact rational-arithmetic pixel model.
module tb_trapezoid_render;

    logic       clk = 1'b0;
    logic       reset;
    logic       nt;
    logic [7:0] xi;
    logic [7:0] yi;
    logic       busy;
    logic       po;
    logic [7:0] xo;
    logic [7:0] yo;

    always #5 clk = ~clk;

    trapezoid_render dut (
        .clk   (clk),
        .reset (reset),
        .nt    (nt),
        .xi    (xi),
        .yi    (yi),
        .busy  (busy),
        .po    (po),
        .xo    (xo),
        .yo    (yo)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int cyc = 0;
    int last_po_cyc = -10;
    int fall_cyc = -10;
    int last_y = -1;
    bit prev_busy = 1'b0;
    bit have_prev = 1'b0;

    // Pixel sink: records every pixel, checks busy coverage and in-row contiguity.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (po) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        failures++;
                        $display("FAIL po_busy: busy=%0b required=1 at pixel (%0d,%0d)",
                                 busy, xo, yo);
                    end
                    if (have_prev && int'(yo) == last_y) begin
                        checks++;
                        if (last_po_cyc != cyc - 1) begin
                            failures++;
                            $display("FAIL row_gap: pixel (%0d,%0d) gap=%0d required=1",
                                     xo, yo, cyc - last_po_cyc);
                        end
                    end
                    got_q.push_back({xo, yo});
                    last_po_cyc = cyc;
                    last_y      = int'(yo);
                    have_prev   = 1'b1;
                end
                if (prev_busy && !busy) fall_cyc = cyc;
            end
            prev_busy = busy;
        end
    end

    // Reference: exact rational edges, L=ceil, R=floor, rows ascending. Appends to exp_q.
    task automatic model(input logic [7:0] xul, xur, yu, xdl, xdr, yd);
        int dy, k, l, r, nl, nr;
        dy = int'(yu) - int'(yd);
        for (int y = int'(yd); y <= int'(yu); y++) begin
            k = y - int'(yd);
            if (dy == 0) begin
                l = int'(xdl);
                r = int'(xdr);
            end else begin
                nl = int'(xdl) * dy + (int'(xul) - int'(xdl)) * k;
                nr = int'(xdr) * dy + (int'(xur) - int'(xdr)) * k;
                l  = (nl + dy - 1) / dy;
                r  = nr / dy;
            end
            for (int x = l; x <= r; x++) exp_q.push_back({8'(x), 8'(y)});
        end
    endtask

    function automatic int budget(input logic [7:0] xul, xur, yu, xdl, xdr, yd, input int npix);
        int dy, ml, mr, mx, per;
        dy  = int'(yu) - int'(yd);
        ml  = int'(xul) - int'(xdl);
        mr  = int'(xur) - int'(xdr);
        if (ml < 0) ml = -ml;
        if (mr < 0) mr = -mr;
        mx  = (ml > mr) ? ml : mr;
        per = 4 + ((dy == 0) ? 0 : (mx + dy - 1) / dy);
        return 8 + npix + (dy + 1) * per;
    endfunction

    // Caller is at negedge+1 with busy=0; vertex 0 goes out on the coming edge.
    task automatic send(input string name, input logic [7:0] xul, xur, yu, xdl, xdr, yd);
        nt = 1'b1; xi = xul; yi = yu;
        @(negedge clk) #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_during_load: busy=%0b required=0", name, busy);
        end
        nt = 1'b0; xi = xur; yi = yu;
        @(negedge clk) #1;
        xi = xdl; yi = yd;
        @(negedge clk) #1;
        xi = xdr; yi = yd;
        @(negedge clk) #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_rise: busy=%0b required=1", name, busy);
        end
        xi = 8'h00; yi = 8'h00;
    endtask

    task automatic wait_done(input string name, input int limit, input bit had_pixels);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk) #1;
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s timeout: busy=%0b after %0d cycles required=0", name, busy, n);
            reset = 1'b1;
            @(negedge clk) #1;
            reset = 1'b0;
        end else if (had_pixels) begin
            checks++;
            if (fall_cyc != last_po_cyc + 1) begin
                failures++;
                $display("FAIL %s busy_fall: fall_cycle=%0d required=%0d",
                         name, fall_cyc, last_po_cyc + 1);
            end
        end
    endtask

    task automatic compare(input string name);
        int bad;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s pixel_count: got=%0d required=%0d", name, got_q.size(),
                     exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s pixel[%0d]: got=(%0d,%0d) required=(%0d,%0d)", name, bad,
                     got_q[bad][15:8], got_q[bad][7:0], exp_q[bad][15:8], exp_q[bad][7:0]);
        end
    endtask

    task automatic clear_capture();
        exp_q.delete();
        got_q.delete();
        have_prev = 1'b0;
    endtask

    task automatic render(input string name, input logic [7:0] xul, xur, yu, xdl, xdr, yd);
        int lim;
        @(negedge clk) #1;
        clear_capture();
        model(xul, xur, yu, xdl, xdr, yd);
        lim = budget(xul, xur, yu, xdl, xdr, yd, exp_q.size());
        send(name, xul, xur, yu, xdl, xdr, yd);
        wait_done(name, lim, exp_q.size() > 0);
        compare(name);
    endtask

    task automatic test_reset();
        reset = 1'b1; nt = 1'b0; xi = 8'h00; yi = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, po, xo, yo} !== 18'h0) begin
            failures++;
            $display("FAIL reset_state: busy=%0b po=%0b xo=%0d yo=%0d required all 0",
                     busy, po, xo, yo);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        render("rectangle", 8'h0a, 8'h0d, 8'h14, 8'h0a, 8'h0d, 8'h12);
        checks++;
        if (got_q.size() != 12 || got_q[0] !== 16'h0a12 || got_q[got_q.size()-1] !== 16'h0d14)
        begin
            failures++;
            $display("FAIL rectangle_ends: count=%0d required=12 first/last (0a,12)/(0d,14)",
                     got_q.size());
        end
        render("triangle", 8'h05, 8'h05, 8'h04, 8'h01, 8'h09, 8'h00);
        checks++;
        if (got_q.size() != 25) begin
            failures++;
            $display("FAIL triangle_count: got=%0d required=25", got_q.size());
        end
        render("frac_right", 8'h00, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00);
        render("ceil_left", 8'h03, 8'h05, 8'h02, 8'h00, 8'h05, 8'h00);
        checks++;
        if (got_q.size() != 13 || (got_q.size() > 6 && got_q[6] !== 16'h0201)) begin
            failures++;
            $display("FAIL ceil_left_row1: count=%0d required=13 with row1 starting at x=2",
                     got_q.size());
        end
        render("flat_dy0", 8'h03, 8'h05, 8'h07, 8'h03, 8'h05, 8'h07);
        render("far_corner", 8'hfe, 8'hff, 8'hff, 8'hf0, 8'hff, 8'hf8);
        render("steep_slope", 8'hc8, 8'hc8, 8'h02, 8'h00, 8'hff, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] xul, xur, yu, xdl, xdr, yd;
        int t;
        for (int i = 0; i < 40; i++) begin
            yd  = 8'($urandom_range(0, 240));
            yu  = 8'(int'(yd) + int'($urandom_range(0, 12)));
            xdl = 8'($urandom_range(0, 255));
            t   = int'(xdl) + int'($urandom_range(0, 30));
            xdr = 8'((t > 255) ? 255 : t);
            xul = 8'($urandom_range(0, 255));
            t   = int'(xul) + int'($urandom_range(0, 30));
            xur = 8'((t > 255) ? 255 : t);
            render("random", xul, xur, yu, xdl, xdr, yd);
        end
    endtask

    task automatic test_back_to_back();
        int lim1, lim2, n1;
        @(negedge clk) #1;
        clear_capture();
        model(8'h10, 8'h14, 8'h0c, 8'h08, 8'h18, 8'h0a);
        n1 = exp_q.size();
        lim1 = budget(8'h10, 8'h14, 8'h0c, 8'h08, 8'h18, 8'h0a, n1);
        model(8'h20, 8'h22, 8'h29, 8'h21, 8'h23, 8'h28);
        lim2 = budget(8'h20, 8'h22, 8'h29, 8'h21, 8'h23, 8'h28, exp_q.size() - n1);
        send("b2b_first", 8'h10, 8'h14, 8'h0c, 8'h08, 8'h18, 8'h0a);
        @(negedge clk) #1;
        nt = 1'b1; xi = 8'h55; yi = 8'h66;
        @(negedge clk) #1;
        nt = 1'b0; xi = 8'h00; yi = 8'h00;
        wait_done("b2b_first", lim1, 1'b1);
        send("b2b_second", 8'h20, 8'h22, 8'h29, 8'h21, 8'h23, 8'h28);
        wait_done("b2b_second", lim2, 1'b1);
        compare("back_to_back");
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk) #1;
        clear_capture();
        send("abort", 8'h00, 8'h64, 8'h14, 8'h00, 8'h64, 8'h0a);
        n = 0;
        while (!po && n < 50) begin
            @(negedge clk) #1;
            n++;
        end
        checks++;
        if (po !== 1'b1) begin
            failures++;
            $display("FAIL abort_emit_start: po=%0b required=1", po);
        end
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk) #1;
        checks++;
        if ({busy, po} !== 2'b00) begin
            failures++;
            $display("FAIL abort_reset: busy=%0b po=%0b required 0 0", busy, po);
        end
        checks++;
        if ({xo, yo} !== 16'h0000) begin
            failures++;
            $display("FAIL abort_reset_xy: xo=%0d yo=%0d required 0 0", xo, yo);
        end
        reset = 1'b0;
        render("after_abort", 8'h03, 8'h06, 8'h22, 8'h01, 8'h08, 8'h20);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
